// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              CpuReq;
    logic              CpuWE;
    logic [ADDR_W-1:0] CpuAddress;
    logic [7:0]        CpuDataIn;
    logic              CpuGnt;
    logic              CpuRdValid;

    logic              DmaReq;
    logic              DmaWE;
    logic              DmaLock;
    logic [ADDR_W-1:0] DmaAddress;
    logic [7:0]        DmaDataIn;
    logic              DmaGnt;
    logic              DmaRdValid;

    logic [7:0]        RdData;

    logic              MemWE;
    logic [ADDR_W-1:0] MemAddress;
    logic [7:0]        MemDataIn;
    logic [7:0]        MemDataOut;

    modport slave (
        input  CpuReq, CpuWE, CpuAddress, CpuDataIn,
        input  DmaReq, DmaWE, DmaLock, DmaAddress, DmaDataIn,
        input  MemDataOut,
        output CpuGnt, CpuRdValid, DmaGnt, DmaRdValid, RdData,
        output MemWE, MemAddress, MemDataIn
    );

    modport master (
        output CpuReq, CpuWE, CpuAddress, CpuDataIn,
        output DmaReq, DmaWE, DmaLock, DmaAddress, DmaDataIn,
        output MemDataOut,
        input  CpuGnt, CpuRdValid, DmaGnt, DmaRdValid, RdData,
        input  MemWE, MemAddress, MemDataIn
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin CPU/DMA arbiter for one synchronous single-port memory, with bounded DMA burst lock.
// Grants and memory drive are combinational (zero latency); RdValid follows a granted read by one cycle.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int MAX_LOCK = 16
) (
    input  logic           CLK,
    input  logic           RESET,
    mem_arbiter_if.slave   bus
);
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    owner_t      last_q, last_d;
    logic        prev_dma_q, prev_dma_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        cpu_rdv_q, cpu_rdv_d;
    logic        dma_rdv_q, dma_rdv_d;

    logic              cpu_gnt;
    logic              dma_gnt;
    logic              lock_hold;
    logic              lock_expired;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;

    // Priority: expired lock hands the CPU its turn, then an active lock, then round-robin.
    always_comb begin
        lock_hold    = prev_dma_q & bus.DmaReq & bus.DmaLock;
        lock_expired = (lock_cnt_q >= LOCK_LIMIT);
        cpu_gnt      = 1'b0;
        dma_gnt      = 1'b0;
        if (bus.CpuReq && bus.DmaReq) begin
            if (lock_expired) begin
                cpu_gnt = 1'b1;
            end else if (lock_hold) begin
                dma_gnt = 1'b1;
            end else if (last_q == OWN_DMA) begin
                cpu_gnt = 1'b1;
            end else begin
                dma_gnt = 1'b1;
            end
        end else begin
            cpu_gnt = bus.CpuReq;
            dma_gnt = bus.DmaReq;
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (cpu_gnt) begin
            mem_we   = bus.CpuWE;
            mem_addr = bus.CpuAddress;
            mem_din  = bus.CpuDataIn;
        end else if (dma_gnt) begin
            mem_we   = bus.DmaWE;
            mem_addr = bus.DmaAddress;
            mem_din  = bus.DmaDataIn;
        end
    end

    always_comb begin
        last_d = last_q;
        if (cpu_gnt) begin
            last_d = OWN_CPU;
        end else if (dma_gnt) begin
            last_d = OWN_DMA;
        end
        prev_dma_d = dma_gnt;
        cpu_rdv_d  = cpu_gnt & ~bus.CpuWE;
        dma_rdv_d  = dma_gnt & ~bus.DmaWE;

        // Only locked DMA wins that actually starve a waiting CPU count toward the limit.
        lock_cnt_d = lock_cnt_q;
        if (!dma_gnt || !bus.DmaLock) begin
            lock_cnt_d = 8'd0;
        end else if (lock_hold && bus.CpuReq && (lock_cnt_q != 8'hFF)) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_q     <= OWN_DMA;
            prev_dma_q <= 1'b0;
            lock_cnt_q <= 8'd0;
            cpu_rdv_q  <= 1'b0;
            dma_rdv_q  <= 1'b0;
        end else begin
            last_q     <= last_d;
            prev_dma_q <= prev_dma_d;
            lock_cnt_q <= lock_cnt_d;
            cpu_rdv_q  <= cpu_rdv_d;
            dma_rdv_q  <= dma_rdv_d;
        end
    end

    assign bus.CpuGnt     = cpu_gnt;
    assign bus.DmaGnt     = dma_gnt;
    assign bus.CpuRdValid = cpu_rdv_q;
    assign bus.DmaRdValid = dma_rdv_q;
    assign bus.RdData     = bus.MemDataOut;
    assign bus.MemWE      = mem_we;
    assign bus.MemAddress = mem_addr;
    assign bus.MemDataIn  = mem_din;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int ADDR_W   = 16;
    localparam int MAX_LOCK = 4;

    logic CLK = 1'b0;
    logic RESET;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port memory, read-first, not affected by reset.
    logic [7:0] mem [0:65535];
    always @(posedge CLK) begin
        if (bus.MemWE) mem[bus.MemAddress] <= bus.MemDataIn;
        bus.MemDataOut <= mem[bus.MemAddress];
    end

    // Reference model state, kept at the level of "who owns the memory" and "what it holds".
    logic [7:0] model_mem [0:65535];
    bit         m_last_dma, m_prev_dma, m_cpu_rdv, m_dma_rdv;
    int         m_lock;
    logic [7:0] m_rd = 8'h00;
    int         exp_win;
    logic       exp_we;
    logic [15:0] exp_addr;
    logic [7:0] exp_din;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic model_reset();
        m_last_dma = 1'b1;
        m_prev_dma = 1'b0;
        m_cpu_rdv  = 1'b0;
        m_dma_rdv  = 1'b0;
        m_lock     = 0;
    endtask

    // Winner: 0 none, 1 CPU, 2 DMA.
    task automatic predict();
        exp_win = 0;
        if (bus.CpuReq && bus.DmaReq) begin
            if (m_lock >= MAX_LOCK)              exp_win = 1;
            else if (m_prev_dma && bus.DmaLock)  exp_win = 2;
            else                                 exp_win = m_last_dma ? 1 : 2;
        end else if (bus.CpuReq) exp_win = 1;
        else if (bus.DmaReq)     exp_win = 2;
        exp_we = 1'b0; exp_addr = 16'h0; exp_din = 8'h0;
        if (exp_win == 1) begin
            exp_we = bus.CpuWE; exp_addr = bus.CpuAddress; exp_din = bus.CpuDataIn;
        end else if (exp_win == 2) begin
            exp_we = bus.DmaWE; exp_addr = bus.DmaAddress; exp_din = bus.DmaDataIn;
        end
    endtask

    task automatic advance();
        bit locked_win;
        predict();
        locked_win = (exp_win == 2) && m_prev_dma && bus.DmaLock;
        m_cpu_rdv = (exp_win == 1) && !bus.CpuWE;
        m_dma_rdv = (exp_win == 2) && !bus.DmaWE;
        if (m_cpu_rdv || m_dma_rdv) m_rd = model_mem[exp_addr];
        if (exp_we) model_mem[exp_addr] = exp_din;
        if (exp_win != 2 || !bus.DmaLock) m_lock = 0;
        else if (locked_win && bus.CpuReq) m_lock = (m_lock < 255) ? m_lock + 1 : 255;
        m_prev_dma = (exp_win == 2);
        if (exp_win != 0) m_last_dma = (exp_win == 2);
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        bus.CpuReq = 0; bus.CpuWE = 0; bus.CpuAddress = '0; bus.CpuDataIn = '0;
        bus.DmaReq = 0; bus.DmaWE = 0; bus.DmaLock = 0; bus.DmaAddress = '0; bus.DmaDataIn = '0;
    endtask

    task automatic set_cpu(input logic we, input logic [15:0] a, input logic [7:0] d);
        bus.CpuReq = 1; bus.CpuWE = we; bus.CpuAddress = a; bus.CpuDataIn = d;
    endtask

    task automatic set_dma(input logic we, input logic lk, input logic [15:0] a, input logic [7:0] d);
        bus.DmaReq = 1; bus.DmaWE = we; bus.DmaLock = lk; bus.DmaAddress = a; bus.DmaDataIn = d;
    endtask

    task automatic apply_reset();
        RESET = 1;
        set_idle();
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 0;
    endtask

    task automatic test_reset();
        RESET = 1;
        set_idle();
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({bus.CpuRdValid, bus.DmaRdValid} !== 2'b00) begin
            n_bad++; $display("FAIL reset_rdvalid: got %b want 00", {bus.CpuRdValid, bus.DmaRdValid});
        end
        n_cmp++;
        if ({bus.CpuGnt, bus.DmaGnt, bus.MemWE, bus.MemAddress} !== 19'h0) begin
            n_bad++; $display("FAIL reset_idle_outputs: gnt=%b%b we=%b addr=%h want all zero",
                              bus.CpuGnt, bus.DmaGnt, bus.MemWE, bus.MemAddress);
        end
        set_cpu(0, 16'h0011, 8'h00);
        set_dma(0, 0, 16'h0022, 8'h00);
        #1;
        n_cmp++;
        if ({bus.CpuGnt, bus.DmaGnt} !== 2'b10) begin
            n_bad++; $display("FAIL reset_contention: got %b want 10", {bus.CpuGnt, bus.DmaGnt});
        end
        set_idle();
        @(posedge CLK);
        #1;
        RESET = 0;
    endtask

    task automatic test_cpu_read();
        set_cpu(0, 16'h0305, 8'h00);
        @(negedge CLK);
        n_cmp++;
        if ({bus.CpuGnt, bus.DmaGnt, bus.MemWE, bus.MemAddress} !== {3'b100, 16'h0305}) begin
            n_bad++; $display("FAIL cpu_read_grant: gnt=%b%b we=%b addr=%h want 1 0 0 0305",
                              bus.CpuGnt, bus.DmaGnt, bus.MemWE, bus.MemAddress);
        end
        advance();
        set_idle();
        @(negedge CLK);
        n_cmp++;
        if ({bus.CpuRdValid, bus.DmaRdValid, bus.RdData} !== {2'b10, 8'hE8}) begin
            n_bad++; $display("FAIL cpu_read_data: rdv=%b%b data=%h want 10 e8",
                              bus.CpuRdValid, bus.DmaRdValid, bus.RdData);
        end
        advance();
        @(negedge CLK);
        n_cmp++;
        if (bus.CpuRdValid !== 1'b0) begin
            n_bad++; $display("FAIL cpu_read_single_pulse: got %b want 0", bus.CpuRdValid);
        end
    endtask

    task automatic test_alternate();
        apply_reset();
        set_cpu(0, 16'h0001, 8'h00);
        set_dma(0, 0, 16'h0002, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({bus.CpuGnt, bus.DmaGnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL alternate_gnt[%0d]: got %b%b", i, bus.CpuGnt, bus.DmaGnt);
            end
            if (i > 0) begin
                n_cmp++;
                if ({bus.CpuRdValid, bus.DmaRdValid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                    n_bad++; $display("FAIL alternate_rdv[%0d]: got %b%b", i, bus.CpuRdValid, bus.DmaRdValid);
                end
            end
            advance();
        end
        set_idle();
        advance();
    endtask

    task automatic test_dma_write();
        set_dma(1, 0, 16'h0000, 8'hA2);
        @(negedge CLK);
        n_cmp++;
        if ({bus.DmaGnt, bus.MemWE, bus.MemAddress, bus.MemDataIn} !== {2'b11, 16'h0000, 8'hA2}) begin
            n_bad++; $display("FAIL dma_write_drive: gnt=%b we=%b addr=%h din=%h want 1 1 0000 a2",
                              bus.DmaGnt, bus.MemWE, bus.MemAddress, bus.MemDataIn);
        end
        advance();
        set_idle();
        set_cpu(0, 16'h0000, 8'h00);
        @(negedge CLK);
        n_cmp++;
        if ({bus.CpuGnt, bus.MemWE, bus.DmaRdValid} !== 3'b100) begin
            n_bad++; $display("FAIL dma_write_then_cpu: gnt=%b we=%b dmardv=%b want 1 0 0",
                              bus.CpuGnt, bus.MemWE, bus.DmaRdValid);
        end
        advance();
        set_idle();
        @(negedge CLK);
        n_cmp++;
        if ({bus.CpuRdValid, bus.DmaRdValid, bus.RdData} !== {2'b10, 8'hA2}) begin
            n_bad++; $display("FAIL dma_write_readback: rdv=%b%b data=%h want 10 a2",
                              bus.CpuRdValid, bus.DmaRdValid, bus.RdData);
        end
        advance();
    endtask

    task automatic test_lock();
        apply_reset();
        set_cpu(0, 16'h0010, 8'h00);
        set_dma(0, 1, 16'h0020, 8'h00);
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({bus.CpuGnt, bus.DmaGnt} !== ((i % 6 == 0) ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL lock_pattern[%0d]: got %b%b", i, bus.CpuGnt, bus.DmaGnt);
            end
            advance();
        end
        set_idle();
        advance();
    endtask

    task automatic test_reset_mid_read();
        set_cpu(0, 16'h0000, 8'h00);
        @(negedge CLK);
        n_cmp++;
        if (bus.CpuGnt !== 1'b1) begin
            n_bad++; $display("FAIL midreset_grant: got %b want 1", bus.CpuGnt);
        end
        advance();
        RESET = 1;
        set_idle();
        model_reset();
        @(negedge CLK);
        n_cmp++;
        if ({bus.CpuRdValid, bus.DmaRdValid} !== 2'b00) begin
            n_bad++; $display("FAIL midreset_rdv_cancel: got %b%b want 00", bus.CpuRdValid, bus.DmaRdValid);
        end
        @(posedge CLK);
        #1;
        RESET = 0;
        set_cpu(0, 16'h0000, 8'h00);
        set_dma(0, 0, 16'h0005, 8'h00);
        @(negedge CLK);
        n_cmp++;
        if ({bus.CpuGnt, bus.DmaGnt} !== 2'b10) begin
            n_bad++; $display("FAIL midreset_contention: got %b%b want 10", bus.CpuGnt, bus.DmaGnt);
        end
        advance();
        set_idle();
        @(negedge CLK);
        n_cmp++;
        if ({bus.CpuRdValid, bus.RdData} !== {1'b1, 8'hA2}) begin
            n_bad++; $display("FAIL midreset_mem_retained: rdv=%b data=%h want 1 a2", bus.CpuRdValid, bus.RdData);
        end
        advance();
    endtask

    task automatic test_idle();
        set_idle();
        advance();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({bus.CpuGnt, bus.DmaGnt, bus.CpuRdValid, bus.DmaRdValid, bus.MemWE, bus.MemAddress, bus.MemDataIn} !== 29'h0) begin
                n_bad++; $display("FAIL idle[%0d]: gnt=%b%b rdv=%b%b we=%b addr=%h din=%h want all zero", i,
                                  bus.CpuGnt, bus.DmaGnt, bus.CpuRdValid, bus.DmaRdValid, bus.MemWE, bus.MemAddress, bus.MemDataIn);
            end
            advance();
        end
    endtask

    task automatic test_random();
        bit cpu_hold = 0;
        bit dma_hold = 0;
        logic [15:0] a;
        for (int i = 0; i < 500; i++) begin
            if (!cpu_hold) begin
                a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                bus.CpuReq = ($urandom_range(0, 3) != 0); bus.CpuWE = $urandom_range(0, 1);
                bus.CpuAddress = a; bus.CpuDataIn = 8'($urandom);
            end
            if (!dma_hold) begin
                a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                bus.DmaReq = ($urandom_range(0, 3) != 0); bus.DmaWE = $urandom_range(0, 1);
                bus.DmaAddress = a; bus.DmaDataIn = 8'($urandom);
            end
            bus.DmaLock = ($urandom_range(0, 4) != 0);
            @(negedge CLK);
            predict();
            n_cmp++;
            if ({bus.CpuGnt, bus.DmaGnt} !== {exp_win == 1, exp_win == 2}) begin
                n_bad++; $display("FAIL rand_gnt[%0d]: got %b%b want winner %0d", i, bus.CpuGnt, bus.DmaGnt, exp_win);
            end
            n_cmp++;
            if ({bus.MemWE, bus.MemAddress, bus.MemDataIn} !== {exp_we, exp_addr, exp_din}) begin
                n_bad++; $display("FAIL rand_mem[%0d]: got %b %h %h want %b %h %h", i,
                                  bus.MemWE, bus.MemAddress, bus.MemDataIn, exp_we, exp_addr, exp_din);
            end
            n_cmp++;
            if ({bus.CpuRdValid, bus.DmaRdValid} !== {m_cpu_rdv, m_dma_rdv}) begin
                n_bad++; $display("FAIL rand_rdv[%0d]: got %b%b want %b%b", i,
                                  bus.CpuRdValid, bus.DmaRdValid, m_cpu_rdv, m_dma_rdv);
            end
            if (m_cpu_rdv || m_dma_rdv) begin
                n_cmp++;
                if (bus.RdData !== m_rd) begin
                    n_bad++; $display("FAIL rand_rddata[%0d]: got %h want %h", i, bus.RdData, m_rd);
                end
            end
            advance();
            cpu_hold = bus.CpuReq && (exp_win != 1);
            dma_hold = bus.DmaReq && (exp_win != 2);
        end
        set_idle();
        advance();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]       = 8'h00;
            model_mem[i] = 8'h00;
        end
        mem[16'h0305]       = 8'hE8;
        model_mem[16'h0305] = 8'hE8;
        bus.MemDataOut = 8'h00;
        test_reset();
        test_cpu_read();
        test_alternate();
        test_dma_write();
        test_lock();
        test_reset_mid_read();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter MAX_LOCK, default 16, maximum consecutive locked DMA grants while the CPU is requesting (range 1..255).
REQ-003 CLK  input  1  single clock, all state updates on posedge.
REQ-004 RESET  input  1  asynchronous active-high reset.
REQ-005 CpuReq, CpuWE  input  1  CPU access request; write when CpuWE=1, else read.
REQ-006 CpuAddress  input  ADDR_W, CpuDataIn  input  8  CPU address and write data.
REQ-007 CpuGnt  output  1  CPU access accepted this cycle (combinational).
REQ-008 CpuRdValid  output  1  registered; CPU read data valid on RdData this cycle.
REQ-009 DmaReq, DmaWE, DmaLock  input  1  DMA request, write select, burst lock.
REQ-010 DmaAddress  input  ADDR_W, DmaDataIn  input  8  DMA address and write data.
REQ-011 DmaGnt  output  1  DMA access accepted this cycle (combinational).
REQ-012 DmaRdValid  output  1  registered; DMA read data valid on RdData this cycle.
REQ-013 RdData  output  8  read data shared by both requesters, equal to MemDataOut.
REQ-014 MemWE  output  1, MemAddress  output  ADDR_W, MemDataIn  output  8  drive the synchronous single-port memory.
REQ-015 MemDataOut  input  8  memory read data, registered by the memory one cycle after the address is sampled.

Function
REQ-016 At most one of CpuGnt/DmaGnt SHALL be high in any cycle; a grant SHALL be issued only to a requester whose Req is high.
REQ-017 A granted access SHALL complete in the cycle it is granted; the requester holds its inputs until it sees Gnt, then may change them.
REQ-018 Mem outputs SHALL be driven combinationally from the granted requester; with no grant, MemWE=0, MemAddress=0 and MemDataIn=0.
REQ-019 Arbitration SHALL be round-robin using a registered last-owner flag (CPU/DMA): when both request, the requester that was not last granted wins.
REQ-020 Lock: if DMA won the previous cycle, DmaReq=1 and DmaLock=1, DMA SHALL win regardless of round-robin, subject to REQ-021.
REQ-021 An 8-bit lock counter SHALL count consecutive DMA grants won through REQ-020 while CpuReq=1; when it reaches MAX_LOCK and CpuReq=1, the CPU SHALL win the next cycle and the counter SHALL clear.
REQ-022 The lock counter SHALL clear on any CPU grant, any idle cycle, or DmaLock=0, and SHALL saturate rather than wrap.
REQ-023 A granted read SHALL assert the matching RdValid exactly one cycle later for one cycle; writes SHALL never assert RdValid.
REQ-024 Back-to-back grants SHALL be allowed every cycle; RdValid for cycle N and Gnt for cycle N+1 may coincide.
REQ-025 A single requester SHALL be granted every cycle it requests; no bubble is allowed.
REQ-026 The last-owner flag SHALL update only on cycles with a grant.

Reset
REQ-027 While RESET=1: CpuRdValid=0, DmaRdValid=0, lock counter=0, last-owner=DMA (CPU wins first contention); Gnt outputs follow REQ-016 to REQ-020 with this state.
REQ-028 Assertion mid-read SHALL cancel the pending RdValid; the memory content written before reset is retained.

Verification
REQ-029 Reset, then CpuReq=1 read at 0x0305 (MemDataOut=0xE8) -> CpuGnt same cycle, CpuRdValid=1 and RdData=0xE8 next cycle.
REQ-030 Both request continuously without DmaLock -> grants alternate CPU, DMA, CPU, ...; first grant goes to CPU.
REQ-031 DMA writes 0xA2 to 0x0000, then CPU reads 0x0000 -> MemWE=1 only in the DMA grant cycle, CPU later reads 0xA2, DmaRdValid never asserts.
REQ-032 DmaLock=1 and both requesting with MAX_LOCK=4 -> one DMA round-robin grant, 4 locked DMA grants, then 1 CPU grant, repeating.
REQ-033 RESET pulsed in the cycle after a granted CPU read -> CpuRdValid stays 0, and the next contention is granted to the CPU.
REQ-034 No requests -> MemWE=0, MemAddress=0, no Gnt and no RdValid for 10 cycles.
